// File: rtl/bev_rmw_ctrl_pkg.sv
// Shared BEV box types: op and error encodings, 64-bit box record layout, DRAM base and counter limits.
package bev_rmw_ctrl_pkg;

  localparam int          ING_W_DEF = 12;
  localparam logic [11:0] ING_MAX   = 12'd4095;
  localparam logic [16:0] BASE_ADDR_DEF = 17'h10000;

  typedef enum logic [1:0] {
    OP_MAKE   = 2'd0,
    OP_SUPPLY = 2'd1,
    OP_CHECK  = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    NO_ERR = 2'd0,
    NO_EXP = 2'd1,
    NO_ING = 2'd2,
    ING_OF = 2'd3
  } err_e;

  typedef struct packed {
    logic [11:0] black;
    logic [11:0] green;
    logic [7:0]  exp_month;
    logic [11:0] milk;
    logic [11:0] pine;
    logic [7:0]  exp_day;
  } box_rec_t;

  function automatic logic [16:0] box_addr(input logic [16:0] base, input logic [7:0] box);
    return base + {6'd0, box, 3'd0};
  endfunction

  // Expired only when today is strictly after the stored expiry date.
  function automatic logic is_expired(input logic [3:0] mon, input logic [4:0] day,
                                      input logic [7:0] exp_mon, input logic [7:0] exp_day);
    return ({4'd0, mon} > exp_mon) ||
           (({4'd0, mon} == exp_mon) && ({3'd0, day} > exp_day));
  endfunction

endpackage

// File: rtl/bev_ing_alu.sv
// Combinational MAKE/SUPPLY/CHECK arithmetic on one box record; yields the new record, error code and write enable.
module bev_ing_alu
  import bev_rmw_ctrl_pkg::*;
#(
  parameter int ING_W = ING_W_DEF
) (
  input  box_rec_t           rec,
  input  logic [1:0]         op,
  input  logic [4*ING_W-1:0] amt,
  input  logic [3:0]         month,
  input  logic [4:0]         day,
  output box_rec_t           new_rec,
  output err_e               err,
  output logic               wen
);

  localparam logic [ING_W-1:0] SAT = ING_W'(ING_MAX);

  logic [ING_W-1:0] cur [4];
  logic [ING_W-1:0] add [4];
  logic [ING_W-1:0] dif [4];
  logic [ING_W-1:0] sat [4];
  logic [ING_W:0]   sum [4];
  logic             short_any;
  logic             ovf_any;
  logic             expired;

  always_comb begin
    cur[0] = rec.black;
    cur[1] = rec.green;
    cur[2] = rec.milk;
    cur[3] = rec.pine;
    short_any = 1'b0;
    ovf_any   = 1'b0;
    // Amount order on the bus is {black, green, milk, pineapple}, msb first.
    for (int i = 0; i < 4; i++) begin
      add[i] = amt[(3-i)*ING_W +: ING_W];
      sum[i] = {1'b0, cur[i]} + {1'b0, add[i]};
      dif[i] = cur[i] - add[i];
      if (cur[i] < add[i]) short_any = 1'b1;
      if (sum[i][ING_W]) begin
        ovf_any = 1'b1;
        sat[i]  = SAT;
      end else begin
        sat[i]  = sum[i][ING_W-1:0];
      end
    end
    expired = is_expired(month, day, rec.exp_month, rec.exp_day);

    new_rec = rec;
    err     = NO_ERR;
    wen     = 1'b0;
    case (op)
      OP_MAKE: begin
        if (expired) begin
          err = NO_EXP;
        end else if (short_any) begin
          err = NO_ING;
        end else begin
          new_rec.black = dif[0];
          new_rec.green = dif[1];
          new_rec.milk  = dif[2];
          new_rec.pine  = dif[3];
          wen = 1'b1;
        end
      end
      OP_SUPPLY: begin
        // Overflow is reported but the saturated record is still written.
        new_rec.black     = sat[0];
        new_rec.green     = sat[1];
        new_rec.milk      = sat[2];
        new_rec.pine      = sat[3];
        new_rec.exp_month = {4'd0, month};
        new_rec.exp_day   = {3'd0, day};
        err = ovf_any ? ING_OF : NO_ERR;
        wen = 1'b1;
      end
      default: begin
        if (expired) err = NO_EXP;
      end
    endcase
  end

endmodule

// File: rtl/bev_rmw_ctrl.sv
// BEV box read-modify-write sequencer in front of the DRAM bridge; one command in flight, req_ready low while busy.
// Optional single-entry last-box cache under BEV_LAST_BOX_CACHE_EN lets a hit skip the DRAM read.
module bev_rmw_ctrl
  import bev_rmw_ctrl_pkg::*;
#(
  parameter logic [16:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int          ING_W     = ING_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [7:0]         req_box_no,
  input  logic [4*ING_W-1:0] req_amt,
  input  logic [3:0]         req_month,
  input  logic [4:0]         req_day,
  output logic               rsp_valid,
  output logic [1:0]         rsp_err,
  output logic               rsp_complete,
  output logic               C_in_valid,
  output logic [16:0]        C_addr,
  output logic               C_r_wb,
  output logic [63:0]        C_data_w,
  input  logic               C_out_valid,
  input  logic [63:0]        C_data_r
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, CALC, WR_REQ, WR_WAIT, RESP
  } state_e;

  state_e             state, state_n;
  logic [1:0]         op_q;
  logic [7:0]         box_q;
  logic [4*ING_W-1:0] amt_q;
  logic [3:0]         mon_q;
  logic [4:0]         day_q;
  box_rec_t           rec_q;
  err_e               err_q;
  box_rec_t           alu_rec;
  err_e               alu_err;
  logic               alu_wen;
  logic               accept;
  logic               hit;
  err_e               fin_err;

  assign accept  = req_valid && req_ready;
  assign fin_err = (state == CALC) ? alu_err : err_q;

`ifdef BEV_LAST_BOX_CACHE_EN
  logic     cache_vld;
  logic [7:0] cache_box;
  box_rec_t cache_rec;

  assign hit = cache_vld && (cache_box == req_box_no);

  // Cache mirrors whatever DRAM holds for the last box touched.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld <= 1'b0;
      cache_box <= '0;
      cache_rec <= '0;
    end else if (state == RD_WAIT && C_out_valid) begin
      cache_vld <= 1'b1;
      cache_box <= box_q;
      cache_rec <= box_rec_t'(C_data_r);
    end else if (state == WR_WAIT && C_out_valid) begin
      cache_vld <= 1'b1;
      cache_box <= box_q;
      cache_rec <= box_rec_t'(C_data_w);
    end
  end
`else
  assign hit = 1'b0;
`endif

  bev_ing_alu #(.ING_W(ING_W)) u_alu (
    .rec     (rec_q),
    .op      (op_q),
    .amt     (amt_q),
    .month   (mon_q),
    .day     (day_q),
    .new_rec (alu_rec),
    .err     (alu_err),
    .wen     (alu_wen)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = hit ? CALC : RD_REQ;
      RD_REQ:  state_n = RD_WAIT;
      RD_WAIT: if (C_out_valid) state_n = CALC;
      CALC:    state_n = alu_wen ? WR_REQ : RESP;
      WR_REQ:  state_n = WR_WAIT;
      WR_WAIT: if (C_out_valid) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // All outputs are registered off the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= '0;
      box_q        <= '0;
      amt_q        <= '0;
      mon_q        <= '0;
      day_q        <= '0;
      rec_q        <= '0;
      err_q        <= NO_ERR;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= '0;
      rsp_complete <= 1'b0;
      C_in_valid   <= 1'b0;
      C_addr       <= '0;
      C_r_wb       <= 1'b0;
      C_data_w     <= '0;
    end else begin
      req_ready  <= (state_n == IDLE);
      C_in_valid <= (state_n == RD_REQ) || (state_n == WR_REQ);
      rsp_valid  <= (state_n == RESP);

      if (accept) begin
        op_q  <= req_op;
        box_q <= req_box_no;
        amt_q <= req_amt;
        mon_q <= req_month;
        day_q <= req_day;
      end

`ifdef BEV_LAST_BOX_CACHE_EN
      if (accept && hit) rec_q <= cache_rec;
`endif
      if (state == RD_WAIT && C_out_valid) rec_q <= box_rec_t'(C_data_r);
      if (state == CALC) err_q <= alu_err;

      if (state == IDLE && state_n == RD_REQ) begin
        C_addr <= box_addr(BASE_ADDR, req_box_no);
        C_r_wb <= 1'b1;
      end
      // Address recomputed here because a cache hit never drove the read address.
      if (state == CALC && state_n == WR_REQ) begin
        C_addr   <= box_addr(BASE_ADDR, box_q);
        C_r_wb   <= 1'b0;
        C_data_w <= alu_rec;
      end

      if (state_n == RESP) begin
        rsp_err      <= fin_err;
        rsp_complete <= (fin_err == NO_ERR);
      end else begin
        rsp_err      <= '0;
        rsp_complete <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bev_rmw_ctrl.sv
// Self-checking bench for bev_rmw_ctrl: directed and randomized commands against a DRAM/bridge model and a box reference model.
module tb_bev_rmw_ctrl;

`ifdef BEV_LAST_BOX_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [7:0]  req_box_no = '0;
  logic [47:0] req_amt = '0;
  logic [3:0]  req_month = '0;
  logic [4:0]  req_day = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_err;
  logic        rsp_complete;
  logic        C_in_valid;
  logic [16:0] C_addr;
  logic        C_r_wb;
  logic [63:0] C_data_w;
  logic        C_out_valid = 1'b0;
  logic [63:0] C_data_r = '0;

  always #5 clk = ~clk;

  bev_rmw_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_box_no(req_box_no), .req_amt(req_amt),
    .req_month(req_month), .req_day(req_day), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_complete(rsp_complete), .C_in_valid(C_in_valid),
    .C_addr(C_addr), .C_r_wb(C_r_wb), .C_data_w(C_data_w),
    .C_out_valid(C_out_valid), .C_data_r(C_data_r)
  );

  logic [63:0] mem [256];
  int          rd_delay = 1, wr_delay = 1;
  int          rd_cnt = 0, wr_cnt = 0, inv_cyc = 0, rsp_cnt = 0;
  logic [16:0] last_rd_addr = '0, last_wr_addr = '0;
  int          checks = 0, failures = 0;
  bit          mc_vld = 1'b0;
  int          mc_box = 0;

  // DRAM bridge: one request at a time, completion after a programmable delay.
  always begin : bridge
    logic [16:0] a;
    bit          is_rd;
    int          idx;
    @(negedge clk);
    if (C_in_valid === 1'b1) begin
      a     = C_addr;
      is_rd = C_r_wb;
      idx   = int'((a - 17'h10000) >> 3) & 255;
      if (is_rd) begin
        rd_cnt++;
        last_rd_addr = a;
      end else begin
        wr_cnt++;
        last_wr_addr = a;
        mem[idx] = C_data_w;
      end
      repeat (is_rd ? rd_delay : wr_delay) @(posedge clk);
      #1;
      if (is_rd) C_data_r = mem[idx];
      C_out_valid = 1'b1;
      @(posedge clk);
      #1 C_out_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (C_in_valid === 1'b1) inv_cyc <= inv_cyc + 1;
    if (rsp_valid === 1'b1)  rsp_cnt <= rsp_cnt + 1;
  end

  function automatic logic [63:0] mkrec(input int b, input int g, input int m, input int p,
                                        input int em, input int ed);
    return {12'(b), 12'(g), 8'(em), 12'(m), 12'(p), 8'(ed)};
  endfunction

  function automatic logic [47:0] mkamt(input int b, input int g, input int m, input int p);
    return {12'(b), 12'(g), 12'(m), 12'(p)};
  endfunction

  // Reference: counters as plain integers, dates compared as month*256+day.
  function automatic void model(input logic [63:0] rec, input int op, input logic [47:0] amt,
                                input int mon, input int day,
                                output logic [63:0] nrec, output int err, output bit wr);
    int c[4];
    int a[4];
    int em, ed, s;
    bit expd, of, shortage;
    c[0] = int'(rec[63:52]); c[1] = int'(rec[51:40]);
    c[2] = int'(rec[31:20]); c[3] = int'(rec[19:8]);
    em = int'(rec[39:32]);   ed = int'(rec[7:0]);
    a[0] = int'(amt[47:36]); a[1] = int'(amt[35:24]);
    a[2] = int'(amt[23:12]); a[3] = int'(amt[11:0]);
    expd = (mon * 256 + day) > (em * 256 + ed);
    err = 0;
    wr  = 1'b0;
    if (op == 0) begin
      if (expd) err = 1;
      else begin
        shortage = 1'b0;
        for (int k = 0; k < 4; k++) if (c[k] < a[k]) shortage = 1'b1;
        if (shortage) err = 2;
        else begin
          for (int k = 0; k < 4; k++) c[k] = c[k] - a[k];
          wr = 1'b1;
        end
      end
    end else if (op == 1) begin
      of = 1'b0;
      for (int k = 0; k < 4; k++) begin
        s = c[k] + a[k];
        if (s > 4095) begin s = 4095; of = 1'b1; end
        c[k] = s;
      end
      em = mon; ed = day;
      wr = 1'b1;
      err = of ? 3 : 0;
    end else begin
      err = expd ? 1 : 0;
    end
    nrec = mkrec(c[0], c[1], c[2], c[3], em, ed);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle_ready"}, req_ready, 1);
  endtask

  task automatic do_cmd(input int op, input int box, input logic [47:0] amt,
                        input int mon, input int day, input bit hold, input string tag);
    logic [63:0] exp_rec;
    int          exp_err, exp_cyc, rd0, wr0, inv0, n, rdy_busy;
    bit          exp_wr, hit, got;
    logic [1:0]  got_err;
    logic        got_cmp;
    hit = CACHE_EN && mc_vld && (mc_box == box);
    model(mem[box], op, amt, mon, day, exp_rec, exp_err, exp_wr);
    if (exp_wr) exp_cyc = hit ? 3 + wr_delay : 4 + rd_delay + wr_delay;
    else        exp_cyc = hit ? 2 : 3 + rd_delay;
    wait_ready(tag);
    rd0 = rd_cnt; wr0 = wr_cnt; inv0 = inv_cyc;
    req_op = 2'(op); req_box_no = 8'(box); req_amt = amt;
    req_month = 4'(mon); req_day = 5'(day);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    n = 0; got = 1'b0; rdy_busy = 0; got_err = '0; got_cmp = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (req_ready === 1'b1) rdy_busy++;
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        got_err = rsp_err;
        got_cmp = rsp_complete;
      end
    end
    check({tag, " rsp_seen"}, got, 1);
    check({tag, " latency"}, n, exp_cyc);
    check({tag, " rsp_err"}, got_err, exp_err);
    check({tag, " rsp_complete"}, got_cmp, exp_err == 0);
    check({tag, " ready_low_busy"}, rdy_busy, 0);
    @(negedge clk);
    check({tag, " rsp_one_cycle"}, rsp_valid, 0);
    check({tag, " ready_after_rsp"}, req_ready, 1);
    req_valid = 1'b0;
    check({tag, " rd_pulses"}, rd_cnt - rd0, hit ? 0 : 1);
    check({tag, " wr_pulses"}, wr_cnt - wr0, exp_wr);
    check({tag, " in_valid_cycles"}, inv_cyc - inv0, (hit ? 0 : 1) + int'(exp_wr));
    if (!hit)   check({tag, " rd_addr"}, last_rd_addr, 65536 + 8 * box);
    if (exp_wr) check({tag, " wr_addr"}, last_wr_addr, 65536 + 8 * box);
    check({tag, " record"}, mem[box], exp_rec);
    mc_vld = 1'b1;
    mc_box = box;
  endtask

  initial begin
    int rsp0, inv0;
    for (int i = 0; i < 256; i++)
      mem[i] = mkrec($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
                     $urandom_range(0, 4095), $urandom_range(1, 12), $urandom_range(1, 31));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", req_ready, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_err", rsp_err, 0);
    check("rst C_in_valid", C_in_valid, 0);
    check("rst C_addr", C_addr, 0);
    check("rst C_data_w", C_data_w, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst ready_after_release", req_ready, 1);

    mem[5] = mkrec(1000, 500, 300, 200, 12, 31);
    do_cmd(0, 5, mkamt(100, 100, 100, 100), 6, 15, 1'b0, "make_ok");
    check("make_ok literal", mem[5], mkrec(900, 400, 200, 100, 12, 31));

    mem[6] = mkrec(1000, 500, 50, 200, 12, 31);
    do_cmd(0, 6, mkamt(0, 0, 51, 0), 6, 15, 1'b0, "make_no_ing");
    check("make_no_ing literal", mem[6], mkrec(1000, 500, 50, 200, 12, 31));
    do_cmd(0, 6, mkamt(10, 10, 10, 10), 12, 31, 1'b0, "make_same_day");
    do_cmd(0, 6, mkamt(10, 10, 10, 10), 1, 1, 1'b0, "make_jan1");
    check("make_jan1 literal", mem[6], mkrec(980, 480, 30, 180, 12, 31));

    mem[9] = mkrec(100, 100, 100, 100, 3, 10);
    do_cmd(0, 9, mkamt(1, 1, 1, 1), 3, 11, 1'b0, "make_expired");
    do_cmd(2, 9, mkamt(0, 0, 0, 0), 3, 10, 1'b0, "check_same_day");
    do_cmd(3, 9, mkamt(0, 0, 0, 0), 4, 1, 1'b0, "check_op3_expired");

    mem[10] = mkrec(4000, 10, 20, 30, 1, 1);
    do_cmd(1, 10, mkamt(200, 0, 0, 0), 9, 9, 1'b0, "supply_of");
    check("supply_of literal", mem[10], mkrec(4095, 10, 20, 30, 9, 9));

    rd_delay = 20; wr_delay = 7;
    mem[11] = mkrec(500, 500, 500, 500, 12, 31);
    do_cmd(0, 11, mkamt(5, 5, 5, 5), 2, 2, 1'b1, "slow_bridge");
    rd_delay = 1; wr_delay = 1;

    // Reset while waiting on the read; the late completion must be ignored.
    rd_delay = 20;
    wait_ready("midrst");
    req_op = 2'd2; req_box_no = 8'd3; req_amt = '0; req_month = 4'd1; req_day = 5'd1;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rsp0 = rsp_cnt;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst ready_low", req_ready, 0);
    check("midrst in_valid_low", C_in_valid, 0);
    rst = 1'b0;
    mc_vld = 1'b0;
    @(negedge clk);
    check("midrst ready_back", req_ready, 1);
    inv0 = inv_cyc;
    repeat (30) @(negedge clk);
    check("midrst no_rsp", rsp_cnt - rsp0, 0);
    check("midrst no_new_request", inv_cyc - inv0, 0);
    check("midrst still_ready", req_ready, 1);
    rd_delay = 1;
    do_cmd(1, 3, mkamt(1, 2, 3, 4), 5, 6, 1'b0, "after_rst");

    mem[7] = mkrec(300, 300, 300, 300, 12, 31);
    do_cmd(0, 7, mkamt(100, 100, 100, 100), 6, 1, 1'b0, "box7_first");
    do_cmd(0, 7, mkamt(100, 100, 100, 100), 6, 1, 1'b0, "box7_second");
    check("box7 literal", mem[7], mkrec(100, 100, 100, 100, 12, 31));
    do_cmd(0, 8, mkamt(0, 0, 0, 0), 1, 1, 1'b0, "box8");

    for (int i = 0; i < 40; i++) begin
      int          op, box;
      logic [47:0] amt;
      box = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
      op  = $urandom_range(0, 3);
      for (int k = 0; k < 4; k++)
        amt[k*12 +: 12] = ($urandom_range(0, 4) == 0) ? 12'($urandom_range(0, 4095))
                                                       : 12'($urandom_range(0, 400));
      rd_delay = $urandom_range(1, 4);
      wr_delay = $urandom_range(1, 4);
      do_cmd(op, box, amt, $urandom_range(1, 12), $urandom_range(1, 31),
             1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
